// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root unit.
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic int root_w(input int width);
      return width / 2;
   endfunction

   function automatic int rem_w(input int width);
      return width / 2 + 1;
   endfunction

   function automatic int iter_n(input int width, input int steps);
      return width / (2 * steps);
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root digit step: brings in two operand bits and
// resolves one root bit.
module sqrt_step #(
   parameter int ROOT_W = 8
) (
   input  logic [ROOT_W:0]   r_in,
   input  logic [ROOT_W-1:0] q_in,
   input  logic [1:0]        bits,
   output logic [ROOT_W:0]   r_out,
   output logic [ROOT_W-1:0] q_out
);

   logic [ROOT_W+1:0] r_sh;
   logic [ROOT_W+1:0] t;
   logic [ROOT_W+1:0] diff;
   logic              ge;
   logic              unused_hi;

   // Before any step the partial root has at most ROOT_W-1 bits and r <= 2q,
   // so the top bits of r_in and q_in are zero and ROOT_W+2 bits hold r', t exactly.
   assign r_sh = {r_in[ROOT_W-1:0], bits};
   assign t    = {q_in[ROOT_W-2:0], 2'b01};
   assign ge   = (r_sh >= t);
   assign diff = r_sh - t;

   assign r_out = ge ? diff[ROOT_W:0] : r_sh[ROOT_W:0];
   assign q_out = {q_in[ROOT_W-2:0], ge};

   assign unused_hi = ^{r_in[ROOT_W], q_in[ROOT_W-1], diff[ROOT_W+1]};

endmodule

// File: rtl/sqrt_seq.sv
// Multi-cycle floor(sqrt(x)) unit with remainder, STEPS root bits per clock,
// valid/ready handshakes on operand and result sides.
module sqrt_seq
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEPS = 1,
   localparam int ROOT_W = root_w(WIDTH),
   localparam int REM_W  = rem_w(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ROOT_W-1:0] root,
   output logic [REM_W-1:0]  rem
);

   localparam int N     = iter_n(WIDTH, STEPS);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  xs;
   logic [REM_W-1:0]  r_acc;
   logic [ROOT_W-1:0] q_acc;
   logic [REM_W-1:0]  r_last;
   logic [ROOT_W-1:0] q_last;

   // Cascade of STEPS combinational steps, each consuming the next operand bit pair.
   for (genvar i = 0; i < STEPS; i++) begin : g_step
      logic [REM_W-1:0]  r_i, r_o;
      logic [ROOT_W-1:0] q_i, q_o;

      if (i == 0) begin : g_first
         assign r_i = r_acc;
         assign q_i = q_acc;
      end else begin : g_next
         assign r_i = g_step[i-1].r_o;
         assign q_i = g_step[i-1].q_o;
      end

      sqrt_step #(.ROOT_W(ROOT_W)) u_step (
         .r_in  (r_i),
         .q_in  (q_i),
         .bits  (xs[WIDTH-1-2*i -: 2]),
         .r_out (r_o),
         .q_out (q_o)
      );
   end

   assign r_last = g_step[STEPS-1].r_o;
   assign q_last = g_step[STEPS-1].q_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = BUSY;
         end
         BUSY: begin
            if (cnt == '0) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         xs    <= '0;
         r_acc <= '0;
         q_acc <= '0;
         root  <= '0;
         rem   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  xs    <= x;
                  r_acc <= '0;
                  q_acc <= '0;
                  cnt   <= CNT_W'(N - 1);
               end
            end
            BUSY: begin
               xs    <= xs << (2 * STEPS);
               r_acc <= r_last;
               q_acc <= q_last;
               if (cnt == '0) begin
                  root <= q_last;
                  rem  <= r_last;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_seq.sv
// Scoreboard bench for sqrt_seq: default 16-bit instance plus a 32-bit, 4-step instance.
module tb_sqrt_seq;

   typedef struct {
      longint x;
      longint root;
      longint rem;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] x;
   logic [7:0]  root;
   logic [8:0]  rem;

   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [31:0] x32;
   logic [15:0] root32;
   logic [16:0] rem32;

   exp_t q16[$];
   exp_t q32[$];

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   sqrt_seq dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .root      (root),
      .rem       (rem)
   );

   sqrt_seq #(.WIDTH(32), .STEPS(4)) dut32 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .x         (x32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .root      (root32),
      .rem       (rem32)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Binary-search integer square root, independent of the digit recurrence.
   function automatic longint isqrt(input longint v);
      longint lo = 0;
      longint hi = 65536;
      longint mid;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= v) lo = mid;
         else                hi = mid - 1;
      end
      return lo;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send16(input logic [15:0] v);
      int     guard = 0;
      longint r;
      in_valid = 1'b1;
      x        = v;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      check("accept_ready16", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      x        = 16'($urandom);
      r        = isqrt(longint'(v));
      q16.push_back('{x: longint'(v), root: r, rem: longint'(v) - r * r});
   endtask

   task automatic wait_valid16(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check("out_valid16", out_valid, 1'b1);
   endtask

   task automatic recv16(input int stall, output int lat);
      exp_t        e;
      logic [63:0] ro;
      logic [63:0] re;
      wait_valid16(lat);
      repeat (stall) tick();
      check("sb_nonempty16", q16.size() != 0, 1'b1);
      if (q16.size() != 0) begin
         e  = q16.pop_front();
         ro = 64'(root);
         re = 64'(rem);
         check("root16", ro, e.root);
         check("rem16", re, e.rem);
         check("root_sq_le_x", ro * ro <= e.x, 1'b1);
         check("x_lt_next_sq", e.x < (ro + 1) * (ro + 1), 1'b1);
         check("rem_eq_x_minus_sq", re, e.x - ro * ro);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid16_drop", out_valid, 1'b0);
   endtask

   task automatic run16(input logic [15:0] v, input int stall);
      int lat;
      send16(v);
      recv16(stall, lat);
   endtask

   task automatic run32(input logic [31:0] v);
      int     lat = 0;
      longint r;
      exp_t   e;
      in_valid32 = 1'b1;
      x32        = v;
      check("accept_ready32", in_ready32, 1'b1);
      tick();
      in_valid32 = 1'b0;
      x32        = $urandom;
      r          = isqrt(longint'(v));
      q32.push_back('{x: longint'(v), root: r, rem: longint'(v) - r * r});
      while (!out_valid32 && lat < 200) begin
         tick();
         lat++;
      end
      check("out_valid32", out_valid32, 1'b1);
      check("latency32", 64'(lat), 64'd4);
      e = q32.pop_front();
      check("root32", 64'(root32), e.root);
      check("rem32", 64'(rem32), e.rem);
      out_ready32 = 1'b1;
      tick();
      out_ready32 = 1'b0;
      check("out_valid32_drop", out_valid32, 1'b0);
   endtask

   initial begin
      int lat;

      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      x           = '0;
      in_valid32  = 1'b0;
      out_ready32 = 1'b0;
      x32         = '0;
      #23;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_root", 64'(root), 64'd0);
      check("rst_rem", 64'(rem), 64'd0);
      check("rst_in_ready32", in_ready32, 1'b1);
      reset = 1'b0;
      tick();

      // Basic results and 8-cycle latency at default parameters.
      send16(16'h0090);
      recv16(0, lat);
      check("latency16", 64'(lat), 64'd8);
      run16(16'h008F, 0);
      run16(16'h0000, 1);
      run16(16'hFFFF, 0);
      run16(16'h0001, 2);

      run32(32'hFFFF_FFFF);
      run32(32'h0001_0000);
      run32(32'h1234_5678);

      // Result held under backpressure; a stray in_valid is not taken.
      send16(16'hFFFF);
      wait_valid16(lat);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            in_valid = 1'b1;
            x        = 16'h0004;
         end
         if (i == 6) in_valid = 1'b0;
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_root", 64'(root), 64'hFF);
         check("bp_rem", 64'(rem), 64'h1FE);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_release_valid", out_valid, 1'b0);
      check("bp_release_ready", in_ready, 1'b1);
      void'(q16.pop_front());
      for (int i = 0; i < 12; i++) begin
         check("bp_no_phantom", out_valid, 1'b0);
         tick();
      end

      // Asynchronous reset three cycles into BUSY discards the operation.
      send16(16'h0090);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_root", 64'(root), 64'd0);
      check("mid_rst_rem", 64'(rem), 64'd0);
      q16.delete();
      #2;
      reset = 1'b0;
      tick();
      for (int i = 0; i < 12; i++) begin
         check("mid_rst_no_output", out_valid, 1'b0);
         tick();
      end
      run16(16'h0051, 0);

      // Sweep: both ends of the range, every square and its predecessor, random fill.
      for (int v = 0; v < 256; v++) run16(16'(v), $urandom_range(0, 3));
      for (int v = 16'hFF00; v <= 16'hFFFF; v++) run16(16'(v), $urandom_range(0, 3));
      for (int k = 1; k < 256; k++) begin
         run16(16'(k * k), $urandom_range(0, 2));
         run16(16'(k * k - 1), $urandom_range(0, 2));
      end
      for (int i = 0; i < 600; i++) run16(16'($urandom), $urandom_range(0, 3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
